cmd_bus_arbiter: RTL and testbench

//  Shares the single 16-bit configuration command bus (Cmd_Out/Cmd_En) between NUM_REQ requesters
//  (e.g. host USB command decoder, power-on config sequencer, calibration scanner).

---
 rtl/cmd_bus_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/cmd_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_cmd_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_bus_pkg.sv
// -----------------------------------------------------------------------------
// cmd_bus_pkg
// Shared definitions for the configuration command bus.
//   - default command word width
//   - opcode / value field positions inside a command word (0-based bits)
//   - FSM state encoding used by cmd_bus_arbiter
//   - small field-extraction helpers for decoders on the bus
// -----------------------------------------------------------------------------
package cmd_bus_pkg;

    localparam int BUS_CMD_WIDTH = 16;

    // Opcode occupies the top nibble, value the low 12 bits.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int VAL_MSB = 11;
    localparam int VAL_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic logic [OPC_MSB-OPC_LSB:0] cmd_opcode(input logic [BUS_CMD_WIDTH-1:0] cmd);
        return cmd[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [VAL_MSB-VAL_LSB:0] cmd_value(input logic [BUS_CMD_WIDTH-1:0] cmd);
        return cmd[VAL_MSB:VAL_LSB];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches Req starting at Ptr and
// wrapping, and reports the first set bit.
// Ports:
//   Req       in   NUM_REQ   request vector
//   Ptr       in   IDX_W     index with highest priority this cycle
//   Grant     out  NUM_REQ   one-hot grant (all zero when no request)
//   Grant_Idx out  IDX_W     index of the granted requester
//   Any       out  1         at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [IDX_W-1:0]   Ptr,
    output logic [NUM_REQ-1:0] Grant,
    output logic [IDX_W-1:0]   Grant_Idx,
    output logic               Any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        Grant     = '0;
        Grant_Idx = '0;
        found     = 1'b0;
        idx       = '0;
        // Walk the ring Ptr, Ptr+1, ... and keep the first hit only.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(Ptr) + k) % NUM_REQ);
            if (!found && Req[idx]) begin
                found      = 1'b1;
                Grant[idx] = 1'b1;
                Grant_Idx  = idx;
            end
        end
    end

    assign Any = |Req;

endmodule

// File: rtl/cmd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_bus_arbiter
// Shares one configuration command bus between NUM_REQ requesters using
// round-robin arbitration and a valid/ready handshake. Each accepted command
// is driven with a one-cycle Cmd_En strobe followed by GAP_CYCLES idle cycles.
// Ports:
//   Clk_In     in   1                   system clock
//   Rst        in   1                   asynchronous active-high reset
//   Req_Valid  in   NUM_REQ             requester i has a command pending
//   Req_Cmd    in   NUM_REQ*CMD_WIDTH   packed commands, slice i = requester i
//   Req_Ready  out  NUM_REQ             one-hot accept pulse (combinational)
//   Cmd_Out    out  CMD_WIDTH           shared command bus
//   Cmd_En     out  1                   strobe qualifying Cmd_Out
//   Bus_Busy   out  1                   high in ISSUE and GAP
//   Last_Src   out  clog2(NUM_REQ)      source of the command on Cmd_Out
//   Issued_Cnt out  16                  number of strobes issued, wrapping
// -----------------------------------------------------------------------------
module cmd_bus_arbiter
    import cmd_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int CMD_WIDTH  = BUS_CMD_WIDTH,
    parameter int GAP_CYCLES = 2,
    parameter int GAP_WIDTH  = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                         Clk_In,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req_Valid,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] Req_Cmd,
    output logic [NUM_REQ-1:0]           Req_Ready,
    output logic [CMD_WIDTH-1:0]         Cmd_Out,
    output logic                         Cmd_En,
    output logic                         Bus_Busy,
    output logic [IDX_W-1:0]             Last_Src,
    output logic [15:0]                  Issued_Cnt
);

    // Counter reload on leaving ISSUE; GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_WIDTH'(GAP_CYCLES - 1) : '0;

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [GAP_WIDTH-1:0] gap_cnt_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     ptr_next;
    logic [CMD_WIDTH-1:0] cmd_out_reg;
    logic [IDX_W-1:0]     last_src_reg;
    logic [15:0]          issued_cnt_reg;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 accept;

    logic [CMD_WIDTH-1:0] req_cmd_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_cmd_arr[gi] = Req_Cmd[gi*CMD_WIDTH +: CMD_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .Req       (Req_Valid),
        .Ptr       (rr_ptr_reg),
        .Grant     (arb_grant),
        .Grant_Idx (arb_idx),
        .Any       (arb_any)
    );

    assign accept   = (state_reg == ST_IDLE) && arb_any;
    assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

    // State register
    always_ff @(posedge Clk_In or posedge Rst) begin
        if (Rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (arb_any) state_next = ST_ISSUE;
            ST_ISSUE: state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt_reg == '0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic. Req_Ready is masked by Rst so no accept is signalled
    // while reset is held, even in the cycle reset is first applied.
    always_comb begin
        Req_Ready = (accept && !Rst) ? arb_grant : '0;
        Cmd_En    = (state_reg == ST_ISSUE);
        Bus_Busy  = (state_reg != ST_IDLE);
    end

    // Datapath: command latch, source, pointer, gap counter, strobe counter.
    always_ff @(posedge Clk_In or posedge Rst) begin
        if (Rst) begin
            cmd_out_reg    <= '0;
            last_src_reg   <= '0;
            rr_ptr_reg     <= '0;
            gap_cnt_reg    <= '0;
            issued_cnt_reg <= '0;
        end else begin
            if (accept) begin
                cmd_out_reg  <= req_cmd_arr[arb_idx];
                last_src_reg <= arb_idx;
                rr_ptr_reg   <= ptr_next;
            end
            if (state_reg == ST_ISSUE) begin
                issued_cnt_reg <= issued_cnt_reg + 16'd1;
                gap_cnt_reg    <= GAP_LOAD;
            end else if ((state_reg == ST_GAP) && (gap_cnt_reg != '0)) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
        end
    end

    assign Cmd_Out    = cmd_out_reg;
    assign Last_Src   = last_src_reg;
    assign Issued_Cnt = issued_cnt_reg;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
module tb_cmd_bus_arbiter;

    logic        clk;
    logic        rst;

    // Main instance, GAP_CYCLES = 2
    logic [1:0]  valid;
    logic [15:0] c0, c1;
    logic [1:0]  ready;
    logic [15:0] cmd_out;
    logic        cmd_en, busy;
    logic        src;
    logic [15:0] cnt;

    // Second instance, GAP_CYCLES = 0
    logic [1:0]  valid0;
    logic [15:0] c0_0;
    logic [1:0]  ready0;
    logic [15:0] cmd_out0;
    logic        cmd_en0, busy0;
    logic        src0;
    logic [15:0] cnt0;

    int checks = 0;
    int errors = 0;

    cmd_bus_arbiter #(.NUM_REQ(2), .CMD_WIDTH(16), .GAP_CYCLES(2), .GAP_WIDTH(4)) dut (
        .Clk_In(clk), .Rst(rst), .Req_Valid(valid), .Req_Cmd({c1, c0}),
        .Req_Ready(ready), .Cmd_Out(cmd_out), .Cmd_En(cmd_en), .Bus_Busy(busy),
        .Last_Src(src), .Issued_Cnt(cnt)
    );

    cmd_bus_arbiter #(.NUM_REQ(2), .CMD_WIDTH(16), .GAP_CYCLES(0), .GAP_WIDTH(4)) dut0 (
        .Clk_In(clk), .Rst(rst), .Req_Valid(valid0), .Req_Cmd({16'h0000, c0_0}),
        .Req_Ready(ready0), .Cmd_Out(cmd_out0), .Cmd_En(cmd_en0), .Bus_Busy(busy0),
        .Last_Src(src0), .Issued_Cnt(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [1:0]  rdy;
        logic        en;
        logic        busy;
        logic [15:0] cmd;
        logic        src;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic row(input logic r, input logic [1:0] v, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] rdy, input logic en, input logic bz,
                       input logic [15:0] cmd, input logic s, input logic [15:0] n);
        vec_t t;
        t.rst = r; t.v = v; t.c0 = a; t.c1 = b;
        t.rdy = rdy; t.en = en; t.busy = bz; t.cmd = cmd; t.src = s; t.cnt = n;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] q [3];

    initial begin
        rst = 1'b1; valid = '0; c0 = '0; c1 = '0; valid0 = '0; c0_0 = '0;

        //   rst v     c0        c1         rdy   en   busy cmd       src  cnt
        row(1, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h0000, 0, 16'd0);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h0000, 0, 16'd0);
        // single request, next accept no earlier than T+4
        row(0, 2'b01, 16'h3ABC, 16'h0000,  2'b01, 0, 0, 16'h0000, 0, 16'd0);
        row(0, 2'b01, 16'h4DEF, 16'h0000,  2'b00, 1, 1, 16'h3ABC, 0, 16'd0);
        row(0, 2'b01, 16'h4DEF, 16'h0000,  2'b00, 0, 1, 16'h3ABC, 0, 16'd1);
        row(0, 2'b01, 16'h4DEF, 16'h0000,  2'b00, 0, 1, 16'h3ABC, 0, 16'd1);
        row(0, 2'b01, 16'h4DEF, 16'h0000,  2'b01, 0, 0, 16'h3ABC, 0, 16'd1);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 1, 1, 16'h4DEF, 0, 16'd1);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 1, 16'h4DEF, 0, 16'd2);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 1, 16'h4DEF, 0, 16'd2);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h4DEF, 0, 16'd2);
        // reset from idle clears everything, pointer back to 0
        row(1, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h0000, 0, 16'd0);
        // contention: alternate 0,1,0,1 with 4-cycle spacing
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b01, 0, 0, 16'h0000, 0, 16'd0);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 1, 1, 16'h1001, 0, 16'd0);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 0, 1, 16'h1001, 0, 16'd1);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 0, 1, 16'h1001, 0, 16'd1);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b10, 0, 0, 16'h1001, 0, 16'd1);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 1, 1, 16'h2002, 1, 16'd1);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 0, 1, 16'h2002, 1, 16'd2);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 0, 1, 16'h2002, 1, 16'd2);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b01, 0, 0, 16'h2002, 1, 16'd2);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 1, 1, 16'h1001, 0, 16'd2);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 0, 1, 16'h1001, 0, 16'd3);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 0, 1, 16'h1001, 0, 16'd3);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b10, 0, 0, 16'h1001, 0, 16'd3);
        row(0, 2'b11, 16'h1001, 16'h2002,  2'b00, 1, 1, 16'h2002, 1, 16'd3);
        // withdrawal: req1 valid in GAP, dropped before IDLE
        row(0, 2'b10, 16'h0000, 16'h2002,  2'b00, 0, 1, 16'h2002, 1, 16'd4);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 1, 16'h2002, 1, 16'd4);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h2002, 1, 16'd4);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h2002, 1, 16'd4);
        // pointer at 0 but only req1 valid: wrap search grants 1
        row(0, 2'b10, 16'h0000, 16'h5A5A,  2'b10, 0, 0, 16'h2002, 1, 16'd4);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 1, 1, 16'h5A5A, 1, 16'd4);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 1, 16'h5A5A, 1, 16'd5);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 1, 16'h5A5A, 1, 16'd5);
        row(0, 2'b00, 16'h0000, 16'h0000,  2'b00, 0, 0, 16'h5A5A, 1, 16'd5);

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            rst = vq[i].rst; valid = vq[i].v; c0 = vq[i].c0; c1 = vq[i].c1;
            @(negedge clk);
            chk("ready", 32'(ready), 32'(vq[i].rdy));
            chk("cmd_en", 32'(cmd_en), 32'(vq[i].en));
            chk("busy", 32'(busy), 32'(vq[i].busy));
            chk("cmd_out", 32'(cmd_out), 32'(vq[i].cmd));
            chk("last_src", 32'(src), 32'(vq[i].src));
            chk("issued_cnt", 32'(cnt), 32'(vq[i].cnt));
            $display("row %0d rst=%b v=%b rdy=%b en=%b busy=%b cmd=%h src=%0d cnt=%0d",
                     i, rst, valid, ready, cmd_en, busy, cmd_out, src, cnt);
        end

        // Reset asserted in the ISSUE cycle; outputs clear immediately.
        tick(); valid = 2'b01; c0 = 16'h7777; c1 = 16'h0000;
        @(negedge clk); chk("rst_seq_ready", 32'(ready), 32'h1);
        tick(); chk("rst_seq_en_before", 32'(cmd_en), 32'h1);
        chk("rst_seq_cmd_before", 32'(cmd_out), 32'h7777);
        rst = 1'b1; #1;
        chk("rst_async_en", 32'(cmd_en), 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        chk("rst_async_cmd", 32'(cmd_out), 32'h0);
        chk("rst_async_src", 32'(src), 32'h0);
        chk("rst_async_cnt", 32'(cnt), 32'h0);
        chk("rst_async_ready", 32'(ready), 32'h0);
        $display("txn reset-in-issue en=%b busy=%b cmd=%h cnt=%0d", cmd_en, busy, cmd_out, cnt);
        tick(); valid = 2'b11; c0 = 16'h1111; c1 = 16'h2222;
        @(negedge clk); chk("rst_held_ready", 32'(ready), 32'h0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("post_rst_grant", 32'(ready), 32'h1);
        tick(); chk("post_rst_en", 32'(cmd_en), 32'h1);
        chk("post_rst_cmd", 32'(cmd_out), 32'h1111);
        chk("post_rst_src", 32'(src), 32'h0);
        $display("txn post-reset grant src=%0d cmd=%h", src, cmd_out);
        valid = 2'b00;
        tick(); tick(); tick();

        // Issued_Cnt wrap from 0xFFFF.
        force dut.issued_cnt_reg = 16'hFFFF;
        #1;
        release dut.issued_cnt_reg;
        chk("wrap_preload", 32'(cnt), 32'hFFFF);
        valid = 2'b10; c1 = 16'hBEEF;
        @(negedge clk); chk("wrap_ready", 32'(ready), 32'h2);
        tick(); valid = 2'b00;
        chk("wrap_en", 32'(cmd_en), 32'h1);
        chk("wrap_cnt_during", 32'(cnt), 32'hFFFF);
        tick();
        chk("wrap_cnt_after", 32'(cnt), 32'h0000);
        chk("wrap_cmd", 32'(cmd_out), 32'hBEEF);
        $display("txn wrap cnt=%0h cmd=%h", cnt, cmd_out);
        tick(); tick();

        // GAP_CYCLES=0 instance: held valid with three queued commands.
        q[0] = 16'hA001; q[1] = 16'hB002; q[2] = 16'hC003;
        begin
            int qi;
            qi = 0;
            tick(); valid0 = 2'b01; c0_0 = q[0];
            for (int cyc = 0; cyc < 6; cyc++) begin
                @(negedge clk);
                chk("gap0_ready", 32'(ready0), (cyc % 2 == 0) ? 32'h1 : 32'h0);
                chk("gap0_en", 32'(cmd_en0), (cyc % 2 == 1) ? 32'h1 : 32'h0);
                chk("gap0_busy", 32'(busy0), (cyc % 2 == 1) ? 32'h1 : 32'h0);
                if (cyc % 2 == 1) begin
                    chk("gap0_cmd", 32'(cmd_out0), 32'(q[cyc / 2]));
                    chk("gap0_src", 32'(src0), 32'h0);
                end
                $display("txn gap0 cyc=%0d rdy=%b en=%b cmd=%h", cyc, ready0, cmd_en0, cmd_out0);
                tick();
                if (cyc % 2 == 0) begin
                    qi++;
                    if (qi < 3) c0_0 = q[qi];
                    else valid0 = 2'b00;
                end
            end
            @(negedge clk);
            chk("gap0_final_en", 32'(cmd_en0), 32'h0);
            chk("gap0_final_ready", 32'(ready0), 32'h0);
            chk("gap0_count", 32'(cnt0), 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
